// File: rtl/cpu_run_monitor.sv
// Run controller for the CPU core: sequences core reset, counts RUN cycles and
// latches a pass/fail/timeout verdict once `result` holds a signature long enough.
module cpu_run_monitor #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    RESET_CYCLES   = 4,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter int                    STABLE_CYCLES  = 2,
  parameter logic [DATA_WIDTH-1:0] PASS_VALUE     = DATA_WIDTH'(32'h0000_0001),
  parameter logic [DATA_WIDTH-1:0] FAIL_VALUE     = DATA_WIDTH'(32'h0000_DEAD),
  parameter int                    CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] result,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [CW-1:0]         cycle_count
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int MW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX     = CW'(TIMEOUT_CYCLES);
  localparam logic [MW-1:0] MATCH_GOAL = MW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [RW-1:0] rst_cnt_r, rst_cnt_s;
  logic [CW-1:0] cycle_cnt_r, cycle_cnt_s;
  logic [MW-1:0] match_cnt_r, match_cnt_s, match_next_s;
  logic          cand_fail_r, cand_fail_s;
  logic          cpu_rst_r, cpu_rst_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          pass_r, pass_s;
  logic          fail_r, fail_s;
  logic          timeout_r, timeout_s;
  logic          is_pass_s, is_fail_s, cand_s;

  // Classify the current sample and advance the consecutive-match run length.
  always_comb begin
    is_pass_s    = (result == PASS_VALUE);
    is_fail_s    = (result == FAIL_VALUE);
    cand_s       = is_pass_s | is_fail_s;
    match_next_s = {MW{1'b0}};
    if (!cand_s) begin
      match_next_s = {MW{1'b0}};
    end else if ((match_cnt_r != {MW{1'b0}}) && (cand_fail_r == is_fail_s)) begin
      if (match_cnt_r == MATCH_GOAL) begin
        match_next_s = match_cnt_r;
      end else begin
        match_next_s = match_cnt_r + MW'(1'b1);
      end
    end else begin
      match_next_s = MW'(1'b1);
    end
  end

  // Next state, counters and verdict flags; outputs are derived from the next state.
  always_comb begin
    state_s     = state_r;
    rst_cnt_s   = rst_cnt_r;
    cycle_cnt_s = cycle_cnt_r;
    match_cnt_s = match_cnt_r;
    cand_fail_s = cand_fail_r;
    pass_s      = pass_r;
    fail_s      = fail_r;
    timeout_s   = timeout_r;
    cpu_rst_s   = 1'b1;
    busy_s      = 1'b0;
    done_s      = 1'b0;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s     = S_RESET;
          rst_cnt_s   = {RW{1'b0}};
          cycle_cnt_s = {CW{1'b0}};
          match_cnt_s = {MW{1'b0}};
          cand_fail_s = 1'b0;
          pass_s      = 1'b0;
          fail_s      = 1'b0;
          timeout_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_RESET: begin
        if (rst_cnt_r == RST_LAST) begin
          state_s   = S_RUN;
          rst_cnt_s = {RW{1'b0}};
        end else begin
          rst_cnt_s = rst_cnt_r + RW'(1'b1);
        end
      end
      S_RUN: begin
        if (cycle_cnt_r < TO_MAX) begin
          cycle_cnt_s = cycle_cnt_r + CW'(1'b1);
        end else begin
          cycle_cnt_s = cycle_cnt_r;
        end
        match_cnt_s = match_next_s;
        cand_fail_s = is_fail_s;
        // A verdict on the final RUN edge takes precedence over timeout.
        if (match_next_s == MATCH_GOAL) begin
          state_s = S_DONE;
          pass_s  = ~is_fail_s;
          fail_s  = is_fail_s;
        end else if (cycle_cnt_r == TO_LAST) begin
          state_s   = S_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = S_RUN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    case (state_s)
      S_RESET: begin
        cpu_rst_s = 1'b1;
        busy_s    = 1'b1;
      end
      S_RUN: begin
        cpu_rst_s = 1'b0;
        busy_s    = 1'b1;
      end
      S_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        cpu_rst_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      rst_cnt_r   <= {RW{1'b0}};
      cycle_cnt_r <= {CW{1'b0}};
      match_cnt_r <= {MW{1'b0}};
      cand_fail_r <= 1'b0;
      cpu_rst_r   <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      rst_cnt_r   <= rst_cnt_s;
      cycle_cnt_r <= cycle_cnt_s;
      match_cnt_r <= match_cnt_s;
      cand_fail_r <= cand_fail_s;
      cpu_rst_r   <= cpu_rst_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      fail_r      <= fail_s;
      timeout_r   <= timeout_s;
    end
  end

  assign cpu_rst     = cpu_rst_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign fail        = fail_r;
  assign timeout     = timeout_r;
  assign cycle_count = cycle_cnt_r;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: default instance plus two short-timeout
// instances for the timeout and verdict-vs-timeout tie cases.
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [31:0] result0 = 32'h0, result1 = 32'h0, result2 = 32'h0;
  logic        cpu_rst0, busy0, done0, pass0, fail0, timeout0;
  logic        cpu_rst1, busy1, done1, pass1, fail1, timeout1;
  logic        cpu_rst2, busy2, done2, pass2, fail2, timeout2;
  logic [10:0] cc0;
  logic [4:0]  cc1, cc2;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  cpu_run_monitor dut0 (
    .clk(clk), .rst(rst), .start(start0), .result(result0),
    .cpu_rst(cpu_rst0), .busy(busy0), .done(done0), .pass(pass0),
    .fail(fail0), .timeout(timeout0), .cycle_count(cc0)
  );

  cpu_run_monitor #(.TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .result(result1),
    .cpu_rst(cpu_rst1), .busy(busy1), .done(done1), .pass(pass1),
    .fail(fail1), .timeout(timeout1), .cycle_count(cc1)
  );

  cpu_run_monitor #(.TIMEOUT_CYCLES(16), .STABLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .result(result2),
    .cpu_rst(cpu_rst2), .busy(busy2), .done(done2), .pass(pass2),
    .fail(fail2), .timeout(timeout2), .cycle_count(cc2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset held, then idle with start low
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("rst_cpu_rst", 32'(cpu_rst0), 32'd1);
      check_eq("rst_busy", 32'(busy0), 32'd0);
      check_eq("rst_done", 32'(done0), 32'd0);
      check_eq("rst_cc", 32'(cc0), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("idle_cpu_rst", 32'(cpu_rst0), 32'd1);
      check_eq("idle_busy", 32'(busy0), 32'd0);
      check_eq("idle_done", 32'(done0), 32'd0);
      check_eq("idle_cc", 32'(cc0), 32'd0);
    end

    // Pass path
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    check_eq("pass_busy_k", 32'(busy0), 32'd1);
    check_eq("pass_cpu_rst_k", 32'(cpu_rst0), 32'd1);
    tick(3);
    check_eq("pass_cpu_rst_k3", 32'(cpu_rst0), 32'd1);
    tick(1);
    check_eq("pass_cpu_rst_k4", 32'(cpu_rst0), 32'd0);
    check_eq("pass_cc_run0", 32'(cc0), 32'd0);
    tick(5);
    check_eq("pass_cc5", 32'(cc0), 32'd5);
    check_eq("pass_done_early", 32'(done0), 32'd0);
    result0 = 32'h1;
    tick(1);
    check_eq("pass_done_1st", 32'(done0), 32'd0);
    check_eq("pass_cc6", 32'(cc0), 32'd6);
    tick(1);
    check_eq("pass_done", 32'(done0), 32'd1);
    check_eq("pass_pass", 32'(pass0), 32'd1);
    check_eq("pass_fail", 32'(fail0), 32'd0);
    check_eq("pass_timeout", 32'(timeout0), 32'd0);
    check_eq("pass_cc7", 32'(cc0), 32'd7);
    check_eq("pass_cpu_rst_done", 32'(cpu_rst0), 32'd1);
    check_eq("pass_busy_done", 32'(busy0), 32'd0);
    tick(2);
    check_eq("pass_sticky", 32'(pass0), 32'd1);
    check_eq("pass_cc_frozen", 32'(cc0), 32'd7);

    // Relaunch from DONE, then glitch rejection
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    result0 = 32'h0;
    check_eq("rel_done_clr", 32'(done0), 32'd0);
    check_eq("rel_pass_clr", 32'(pass0), 32'd0);
    check_eq("rel_cc_clr", 32'(cc0), 32'd0);
    check_eq("rel_busy", 32'(busy0), 32'd1);
    check_eq("rel_cpu_rst", 32'(cpu_rst0), 32'd1);
    tick(3);
    check_eq("rel_cpu_rst_k3", 32'(cpu_rst0), 32'd1);
    tick(1);
    check_eq("rel_cpu_rst_k4", 32'(cpu_rst0), 32'd0);
    result0 = 32'h1;
    tick(1);
    result0 = 32'h42;
    tick(1);
    check_eq("glitch_no_pass", 32'(pass0), 32'd0);
    result0 = 32'hDEAD;
    tick(1);
    check_eq("glitch_done_1st_dead", 32'(done0), 32'd0);
    tick(1);
    check_eq("glitch_done", 32'(done0), 32'd1);
    check_eq("glitch_fail", 32'(fail0), 32'd1);
    check_eq("glitch_pass", 32'(pass0), 32'd0);
    check_eq("glitch_timeout", 32'(timeout0), 32'd0);
    check_eq("glitch_cc", 32'(cc0), 32'd4);

    // Timeout with TIMEOUT_CYCLES=16
    result1 = 32'h5;
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(4);
    check_eq("to_cpu_rst_run", 32'(cpu_rst1), 32'd0);
    check_eq("to_cc0", 32'(cc1), 32'd0);
    tick(15);
    check_eq("to_done_early", 32'(done1), 32'd0);
    check_eq("to_cc15", 32'(cc1), 32'd15);
    tick(1);
    check_eq("to_done", 32'(done1), 32'd1);
    check_eq("to_timeout", 32'(timeout1), 32'd1);
    check_eq("to_pass", 32'(pass1), 32'd0);
    check_eq("to_fail", 32'(fail1), 32'd0);
    check_eq("to_cc16", 32'(cc1), 32'd16);
    tick(3);
    check_eq("to_cc_sat", 32'(cc1), 32'd16);
    check_eq("to_sticky", 32'(timeout1), 32'd1);

    // Verdict on the timeout edge wins
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(4);
    tick(15);
    check_eq("tie_done_early", 32'(done2), 32'd0);
    check_eq("tie_cc15", 32'(cc2), 32'd15);
    result2 = 32'h1;
    tick(1);
    check_eq("tie_done", 32'(done2), 32'd1);
    check_eq("tie_pass", 32'(pass2), 32'd1);
    check_eq("tie_timeout", 32'(timeout2), 32'd0);
    check_eq("tie_cc16", 32'(cc2), 32'd16);

    // Async reset mid-RUN
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    result0 = 32'h0;
    tick(4);
    tick(3);
    check_eq("ar_cc3", 32'(cc0), 32'd3);
    check_eq("ar_cpu_rst_run", 32'(cpu_rst0), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("ar_cpu_rst", 32'(cpu_rst0), 32'd1);
    check_eq("ar_busy", 32'(busy0), 32'd0);
    check_eq("ar_done", 32'(done0), 32'd0);
    check_eq("ar_fail", 32'(fail0), 32'd0);
    check_eq("ar_cc", 32'(cc0), 32'd0);
    check_eq("ar_done1", 32'(done1), 32'd0);
    check_eq("ar_cc1", 32'(cc1), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(2);
    check_eq("post_cpu_rst", 32'(cpu_rst0), 32'd1);
    check_eq("post_busy", 32'(busy0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
